// File: rtl/dynamic_input_shifter.sv
// dynamic_input_shifter: per-lane minimal right-shift and rounding of wide operands into a narrower width.
// Two-stage valid/ready pipeline: S1 holds operands and shift amounts, S2 holds the reduced result.
module dynamic_input_shifter #(
    parameter int BITWIDTH     = 16,
    parameter int OUT_BITWIDTH = 8,
    parameter int LANES        = 2,
    parameter int ROUND_MODE   = 1,
    localparam int SHW         = $clog2(BITWIDTH - OUT_BITWIDTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*BITWIDTH-1:0]     in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES*OUT_BITWIDTH-1:0] out_data,
    output logic [LANES*SHW-1:0]          out_shift,
    output logic [15:0]                   shift_count
);
    localparam int D = BITWIDTH - OUT_BITWIDTH;

    logic                          s1_valid, s1_en, s2_en, take;
    logic [LANES*BITWIDTH-1:0]     s1_data;
    logic [LANES*SHW-1:0]          s1_shift, in_shift;
    logic [LANES*OUT_BITWIDTH-1:0] rnd;
    logic [16:0]                   sum;
    logic [15:0]                   cnt_next;

    // Descending scan so the smallest qualifying shift is the one kept.
    function automatic logic [SHW-1:0] min_shift(input logic [BITWIDTH-1:0] v);
        logic [SHW-1:0] s;
        s = SHW'(D);
        for (int k = D; k >= 0; k--)
            if ((v >> (k + OUT_BITWIDTH)) == '0) s = SHW'(k);
        return s;
    endfunction

    // A zero appended below the LSB makes e[0] the dropped bit in[s-1], and 0 when s == 0.
    function automatic logic [OUT_BITWIDTH-1:0] reduce(input logic [BITWIDTH-1:0] v, input logic [SHW-1:0] s);
        logic [BITWIDTH:0]       e;
        logic [OUT_BITWIDTH-1:0] b;
        e = {v, 1'b0} >> s;
        b = OUT_BITWIDTH'(e >> 1);
        return ROUND_MODE == 0 ? b :
               ROUND_MODE == 1 ? {b[OUT_BITWIDTH-1:1], b[0] | e[0]} :
               (&b && e[0]) ? '1 : b + OUT_BITWIDTH'(e[0]);
    endfunction

    assign s2_en    = !out_valid || out_ready;
    assign s1_en    = !s1_valid || s2_en;
    assign in_ready = s1_en;
    assign take     = in_valid && in_ready && !flush;

    always_comb begin
        in_shift = '0;
        rnd      = '0;
        sum      = {1'b0, shift_count};
        for (int i = 0; i < LANES; i++) begin
            in_shift[i*SHW +: SHW]           = min_shift(in_data[i*BITWIDTH +: BITWIDTH]);
            rnd[i*OUT_BITWIDTH +: OUT_BITWIDTH] = reduce(s1_data[i*BITWIDTH +: BITWIDTH], s1_shift[i*SHW +: SHW]);
            sum = sum + 17'(in_shift[i*SHW +: SHW] != '0);
        end
        cnt_next = sum[16] ? 16'hFFFF : sum[15:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_data     <= '0;
            s1_shift    <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_shift   <= '0;
            shift_count <= '0;
        end else begin
            if (flush)
                s1_valid <= 1'b0;
            else if (s1_en)
                s1_valid <= in_valid;
            if (take) begin
                s1_data     <= in_data;
                s1_shift    <= in_shift;
                shift_count <= cnt_next;
            end
            if (flush)
                out_valid <= 1'b0;
            else if (s2_en)
                out_valid <= s1_valid;
            if (s2_en && s1_valid) begin
                out_data  <= rnd;
                out_shift <= s1_shift;
            end
        end
    end
endmodule

// File: tb/tb_dynamic_input_shifter.sv
// tb_dynamic_input_shifter: directed checks of shift selection, rounding modes, handshake, flush and reset.
module tb_dynamic_input_shifter;
    logic        clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 1;
    logic [31:0] in_data = '0;
    logic        ir0, ir1, ir2, ov0, ov1, ov2;
    logic [15:0] od0, od1, od2, sc0, sc1, sc2;
    logic [7:0]  os0, os1, os2;
    int          checks = 0, errors = 0;
    logic [15:0] exp_count = 0;

    always #5 clk = ~clk;

    dynamic_input_shifter #(.ROUND_MODE(0)) m0 (.clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(ir0), .in_data(in_data), .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
        .out_shift(os0), .shift_count(sc0));
    dynamic_input_shifter #(.ROUND_MODE(1)) m1 (.clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(ir1), .in_data(in_data), .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
        .out_shift(os1), .shift_count(sc1));
    dynamic_input_shifter #(.ROUND_MODE(2)) m2 (.clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(ir2), .in_data(in_data), .out_valid(ov2), .out_ready(out_ready), .out_data(od2),
        .out_shift(os2), .shift_count(sc2));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #12;
        checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", ov1); end
        checks++; if (ir1 !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", ir1); end
        checks++; if (sc1 !== 16'h0) begin errors++; $display("FAIL reset_count: got %h expected 0000", sc1); end
        checks++; if (od1 !== 16'h0 || os1 !== 8'h0) begin errors++; $display("FAIL reset_data: got %h/%h expected 0000/00", od1, os1); end
        tick;
        rst_n = 1;
    endtask

    task automatic test_single(input logic [31:0] d, input logic [15:0] e0, input logic [15:0] e1,
                               input logic [15:0] e2, input logic [7:0] es, input int inc);
        in_valid = 1; in_data = d;
        tick;
        in_valid = 0;
        exp_count = exp_count + 16'(inc);
        checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL single_early_valid %h: got %b expected 0", d, ov1); end
        checks++; if (sc1 !== exp_count) begin errors++; $display("FAIL single_count %h: got %h expected %h", d, sc1, exp_count); end
        tick;
        checks++; if (ov1 !== 1'b1) begin errors++; $display("FAIL single_valid %h: got %b expected 1", d, ov1); end
        checks++; if (od0 !== e0) begin errors++; $display("FAIL single_mode0 %h: got %h expected %h", d, od0, e0); end
        checks++; if (od1 !== e1) begin errors++; $display("FAIL single_mode1 %h: got %h expected %h", d, od1, e1); end
        checks++; if (od2 !== e2) begin errors++; $display("FAIL single_mode2 %h: got %h expected %h", d, od2, e2); end
        checks++; if (os1 !== es) begin errors++; $display("FAIL single_shift %h: got %h expected %h", d, os1, es); end
        tick;
        checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL single_drain %h: got %b expected 0", d, ov1); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] ev;
        out_ready = 1;
        for (int c = 0; c < 6; c++) begin
            in_valid = c < 4;
            in_data  = {8'h00, 8'(8'h10 + c), 8'h00, 8'(8'h20 + c)};
            #1;
            if (c < 4) begin
                checks++; if (ir1 !== 1'b1) begin errors++; $display("FAIL b2b_ready c%0d: got %b expected 1", c, ir1); end
            end
            tick;
            if (c >= 1 && c <= 4) begin
                ev = {8'(8'h10 + c - 1), 8'(8'h20 + c - 1)};
                checks++; if (ov1 !== 1'b1 || od1 !== ev) begin errors++; $display("FAIL b2b_out c%0d: got %b/%h expected 1/%h", c, ov1, od1, ev); end
            end
        end
        checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b expected 0", ov1); end
        checks++; if (sc1 !== exp_count) begin errors++; $display("FAIL b2b_count: got %h expected %h", sc1, exp_count); end
    endtask

    task automatic test_backpressure;
        logic [31:0] bset [3];
        logic [15:0] bexp [3];
        int sent, got;
        bset = '{32'h00A1_00B2, 32'h0200_0011, 32'h0033_0044};
        bexp = '{16'hA1B2, 16'h8011, 16'h3344};
        sent = 0; got = 0;
        out_ready = 0;
        for (int c = 0; c < 14; c++) begin
            if (c == 4) out_ready = 1;
            in_valid = sent < 3;
            in_data  = bset[sent < 3 ? sent : 0];
            #1;
            if (c == 2 || c == 3) begin
                checks++; if (ir1 !== 1'b0) begin errors++; $display("FAIL bp_ready c%0d: got %b expected 0", c, ir1); end
                checks++; if (ov1 !== 1'b1 || od1 !== bexp[0]) begin errors++; $display("FAIL bp_hold c%0d: got %b/%h expected 1/%h", c, ov1, od1, bexp[0]); end
                checks++; if (sent !== 2) begin errors++; $display("FAIL bp_accepted c%0d: got %0d expected 2", c, sent); end
            end
            if (ov1 && out_ready) begin
                if (got < 3) begin
                    checks++; if (od1 !== bexp[got]) begin errors++; $display("FAIL bp_order %0d: got %h expected %h", got, od1, bexp[got]); end
                end
                got++;
            end
            if (in_valid && ir1) sent++;
            tick;
        end
        in_valid = 0;
        exp_count = exp_count + 16'd1;
        checks++; if (got !== 3 || sent !== 3) begin errors++; $display("FAIL bp_totals: got %0d/%0d expected 3/3", got, sent); end
        checks++; if (sc1 !== exp_count) begin errors++; $display("FAIL bp_count: got %h expected %h", sc1, exp_count); end
    endtask

    task automatic fill2;
        out_ready = 0;
        in_valid = 1; in_data = 32'h0135_00B7;
        tick;
        in_data = 32'h0100_0135;
        tick;
        in_valid = 0;
        exp_count = exp_count + 16'd3;
    endtask

    task automatic test_flush;
        fill2;
        checks++; if (ov1 !== 1'b1 || ir1 !== 1'b0) begin errors++; $display("FAIL flush_full: got %b/%b expected 1/0", ov1, ir1); end
        flush = 1; in_valid = 1; in_data = 32'hFFFF_FFFF;
        tick;
        flush = 0; in_valid = 0;
        checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", ov1); end
        checks++; if (sc1 !== exp_count) begin errors++; $display("FAIL flush_count: got %h expected %h", sc1, exp_count); end
        checks++; if (ir1 !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b expected 1", ir1); end
        out_ready = 1;
        for (int c = 0; c < 3; c++) begin
            tick;
            checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL flush_stale c%0d: got %b expected 0", c, ov1); end
        end
    endtask

    task automatic test_async_reset;
        fill2;
        #3 rst_n = 0;
        #1;
        exp_count = 0;
        checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b expected 0", ov1); end
        checks++; if (sc1 !== exp_count) begin errors++; $display("FAIL areset_count: got %h expected %h", sc1, exp_count); end
        checks++; if (ir1 !== 1'b1) begin errors++; $display("FAIL areset_ready: got %b expected 1", ir1); end
        tick;
        rst_n = 1;
        out_ready = 1;
        for (int c = 0; c < 3; c++) begin
            tick;
            checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL areset_stale c%0d: got %b expected 0", c, ov1); end
        end
    endtask

    initial begin
        test_reset;
        test_single(32'h0135_00B7, 16'h9AB7, 16'h9BB7, 16'h9BB7, 8'h10, 1);
        test_single(32'h00B7_0000, 16'hB700, 16'hB700, 16'hB700, 8'h00, 0);
        test_single(32'hFFFF_8080, 16'hFF80, 16'hFF81, 16'hFF81, 8'h88, 2);
        test_single(32'h00FF_0100, 16'hFF80, 16'hFF80, 16'hFF80, 8'h01, 1);
        test_single(32'h01FF_7FFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 8'h17, 2);
        test_back_to_back;
        test_backpressure;
        test_flush;
        test_async_reset;
        test_single(32'h0135_0000, 16'h9A00, 16'h9B00, 16'h9B00, 8'h10, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dynamic_input_shifter.md
DYNAMIC_INPUT_SHIFTER -- requirements
Module: dynamic_input_shifter

Interface
REQ-001 SHALL have parameter BITWIDTH, default 16, meaning the full operand width per lane.
REQ-002 SHALL have parameter OUT_BITWIDTH, default 8, meaning the reduced operand width (2 <= OUT_BITWIDTH < BITWIDTH).
REQ-003 SHALL have parameter LANES, default 2, meaning the number of independent operand lanes sharing one handshake.
REQ-004 SHALL have parameter ROUND_MODE, default 1, meaning LSB rounding: 0 truncate, 1 OR-of-two, 2 round-half-up saturating.
REQ-005 SHALL derive localparam SHW = $clog2(BITWIDTH-OUT_BITWIDTH+1), the shift-amount width.
REQ-006 Ports (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of pipeline contents.
- in_valid  in  1  input operands valid.
- in_ready  out  1  block can accept operands this cycle.
- in_data  in  LANES*BITWIDTH  unsigned operands, lane i at [i*BITWIDTH +: BITWIDTH].
- out_valid  out  1  reduced operands valid.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  LANES*OUT_BITWIDTH  reduced operands, same lane packing.
- out_shift  out  LANES*SHW  right-shift applied per lane.
- shift_count  out  16  saturating count of accepted lanes with nonzero shift.

Function
REQ-007 Per lane, the block SHALL select s = minimal value in 0..BITWIDTH-OUT_BITWIDTH such that (in >> s) < 2^OUT_BITWIDTH.
REQ-008 s = 0 SHALL yield out = in[OUT_BITWIDTH-1:0] unchanged, in every ROUND_MODE.
REQ-009 For s > 0, base value b = in[s +: OUT_BITWIDTH].
REQ-010 ROUND_MODE 0: out = b.
REQ-011 ROUND_MODE 1: out = {b[OUT_BITWIDTH-1:1], in[s] | in[s-1]}.
REQ-012 ROUND_MODE 2: out = b + in[s-1]; on overflow, out SHALL saturate to all ones.
REQ-013 Pipeline SHALL be 2 stages: S1 registers operands and per-lane s; S2 registers out_data and out_shift; latency SHALL be exactly 2 cycles with no stall.
REQ-014 A transfer occurs on an edge where valid and ready are both high; in_valid, in_data and out_* SHALL be held stable by the sender while valid is high and ready is low.
REQ-015 S2 load enable = !out_valid || out_ready; S1 advance enable = !s1_valid || S2 load enable; in_ready SHALL equal the S1 advance enable.
REQ-016 Throughput SHALL be one operand set per cycle while out_ready stays high.
REQ-017 With out_ready low, the block SHALL hold at most 2 sets, and in_ready SHALL deassert once both stages are full.
REQ-018 flush high SHALL clear both stage valids at the next edge and SHALL ignore any input offered that cycle.
REQ-019 out_data and out_shift SHALL only be defined while out_valid is high.
REQ-020 shift_count SHALL increment by the number of lanes with s > 0 on each input transfer, saturate at 0xFFFF, and SHALL NOT be cleared by flush.

Reset
REQ-021 rst_n low SHALL asynchronously clear S1/S2 valid flags, out_valid, out_data, out_shift and shift_count to 0.
REQ-022 During reset in_ready SHALL read 1 (pipeline empty); the first transfer SHALL be possible on the first edge after rst_n rises.
REQ-023 Reset asserted mid-operation SHALL discard all in-flight sets with no output produced.

Verification (BITWIDTH=16, OUT_BITWIDTH=8, LANES=2 unless stated)
REQ-024 Lane in 0x00B7, any mode -> out 0xB7, shift 0, two cycles after acceptance; shift_count unchanged.
REQ-025 Lane in 0x0135 -> shift 1; out 0x9A (mode 0), 0x9B (mode 1), 0x9B (mode 2); shift_count +1.
REQ-026 Lane in 0xFFFF, mode 2 -> shift 8, out 0xFF (saturated); 0x8080, mode 1 -> shift 8, out 0x81.
REQ-027 Offer 3 back-to-back sets, out_ready low 4 cycles -> 2 accepted, in_ready low, out_data stable; after out_ready rises, all 3 sets emerge in order with no loss or duplication.
REQ-028 rst_n pulsed low with 2 sets in flight -> out_valid 0 immediately, shift_count 0, no stale output after release; flush with 2 sets in flight -> out_valid 0 next cycle, shift_count retained.
